// File: rtl/multu_pkg.sv
// Shared definitions for the sequential unsigned multiplier: FSM states and default width.
package multu_pkg;

  localparam int unsigned MULTU_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : multu_pkg

// File: rtl/multu_seq_if.sv
// Request/result bundle of the sequential multiplier.
// master drives start/a/b and observes the result; slave is the multiplier.
interface multu_seq_if
  import multu_pkg::*;
#(
  parameter int unsigned WIDTH = MULTU_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output a,
    output b,
    input  hi,
    input  lo,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output hi,
    output lo,
    output busy,
    output done
  );

endinterface : multu_seq_if

// File: rtl/multu_step.sv
// One radix-2 add-shift step of the multiplier; purely combinational.
module multu_step
  import multu_pkg::*;
#(
  parameter int unsigned WIDTH = MULTU_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplr,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplr_next
);

  // Conditionally add the shifted multiplicand, then advance both operands.
  always_comb begin
    acc_next   = acc;
    mcand_next = mcand << 1;
    mplr_next  = mplr >> 1;
    if (mplr[0]) begin
      acc_next = acc + mcand;
    end
  end

endmodule : multu_step

// File: rtl/multu_seq.sv
// Sequential unsigned multiplier, one radix-2 step per RUN cycle.
// {hi,lo} is updated only when an operation completes and otherwise holds.
// Optional macro MULTU_SEQ_EARLY_EXIT_EN ends RUN as soon as the remaining
// multiplier is zero; without it RUN always lasts WIDTH cycles.
module multu_seq
  import multu_pkg::*;
#(
  parameter int unsigned WIDTH = MULTU_WIDTH
) (
  input logic        clock,
  input logic        reset,
  multu_seq_if.slave bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [PW-1:0]    acc_nx;
  logic [PW-1:0]    mcand_nx;
  logic [WIDTH-1:0] mplr_nx;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic             accept_c;
  logic             last_step_c;

  multu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc        (acc_q),
    .mcand      (mcand_q),
    .mplr       (mplr_q),
    .acc_next   (acc_nx),
    .mcand_next (mcand_nx),
    .mplr_next  (mplr_nx)
  );

  // Decide whether the step performed this cycle is the final one.
  always_comb begin
    last_step_c = 1'b0;
`ifdef MULTU_SEQ_EARLY_EXIT_EN
    last_step_c = (cnt_q == LAST_CNT) || (mplr_nx == '0);
`else
    last_step_c = (cnt_q == LAST_CNT);
`endif
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (last_step_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand latch on accept, one add-shift step per RUN cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else if (accept_c) begin
      acc_q   <= '0;
      mcand_q <= {{WIDTH{1'b0}}, bus.a};
      mplr_q  <= bus.b;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      acc_q   <= acc_nx;
      mcand_q <= mcand_nx;
      mplr_q  <= mplr_nx;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Result register, written only on the RUN->DONE transition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if ((state_q == RUN) && last_step_c) begin
      {hi_q, lo_q} <= acc_nx;
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule : multu_seq

// File: tb/tb_multu_seq.sv
// Directed bench for multu_seq; cycle 0 is the cycle in which start is high.
module tb_multu_seq;
  import multu_pkg::*;

  localparam int unsigned W = MULTU_WIDTH;

`ifdef MULTU_SEQ_EARLY_EXIT_EN
  localparam int L_3X5   = 4;
  localparam int L_FFXFF = 33;
  localparam int L_7X9   = 5;
  localparam int POKE    = 2;
  localparam int L_4X4   = 4;
  localparam int L_6X7   = 4;
  localparam int L_10X10 = 5;
  localparam int L_9X0   = 2;
  localparam int L_FFX1  = 2;
  localparam int L_MSB   = 33;
`else
  localparam int L_3X5   = 33;
  localparam int L_FFXFF = 33;
  localparam int L_7X9   = 33;
  localparam int POKE    = 10;
  localparam int L_4X4   = 33;
  localparam int L_6X7   = 33;
  localparam int L_10X10 = 33;
  localparam int L_9X0   = 33;
  localparam int L_FFX1  = 33;
  localparam int L_MSB   = 33;
`endif

  logic clock = 1'b0;
  logic reset;

  multu_seq_if #(.WIDTH(W)) bus ();

  multu_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issue one multiply and follow it to its done pulse. prev_* is the result
  // that must still be held during RUN; poke_cyc pulses a stray start (a=b=2);
  // chain leaves the bench inside the DONE cycle for a back-to-back start.
  task automatic run_op(input string tag, input logic [31:0] oa, input logic [31:0] ob,
                        input int exp_cyc, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                        input int poke_cyc, input bit chain);
    int cyc;
    bit seen;
    int busy_gaps;
    cyc       = 0;
    seen      = 1'b0;
    busy_gaps = 0;
    bus.start = 1'b1;
    bus.a     = oa;
    bus.b     = ob;
    next_cycle();
    bus.start = 1'b0;
    cyc       = 1;
    while (!seen && cyc <= 100) begin
      @(negedge clock);
      if (cyc == 1) begin
        check({tag, " hold_hi"}, 64'(bus.hi), 64'(prev_hi));
        check({tag, " hold_lo"}, 64'(bus.lo), 64'(prev_lo));
      end
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (!bus.busy) busy_gaps++;
        next_cycle();
        cyc++;
        if (cyc == poke_cyc) begin
          bus.start = 1'b1;
          bus.a     = 32'd2;
          bus.b     = 32'd2;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check({tag, " done_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " busy_gaps"}, 64'(busy_gaps), 64'd0);
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, " hi"}, 64'(bus.hi), 64'(ehi));
    check({tag, " lo"}, 64'(bus.lo), 64'(elo));
    if (!chain) next_cycle();
  endtask

  initial begin
    int dones;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    next_cycle();
    next_cycle();
    check("rst hi", 64'(bus.hi), 64'd0);
    check("rst lo", 64'(bus.lo), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    next_cycle();

    run_op("3x5", 32'd3, 32'd5, L_3X5, 32'h0, 32'hF, 32'h0, 32'h0, -1, 1'b0);
    run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, L_FFXFF, 32'hFFFF_FFFE, 32'h1,
           32'h0, 32'hF, -1, 1'b0);

    // Result must persist through idle cycles.
    repeat (5) next_cycle();
    check("idle hold hi", 64'(bus.hi), 64'hFFFF_FFFE);
    check("idle hold lo", 64'(bus.lo), 64'h1);

    run_op("7x9 poke", 32'd7, 32'd9, L_7X9, 32'h0, 32'd63,
           32'hFFFF_FFFE, 32'h1, POKE, 1'b0);

    // Abort mid-RUN with reset in cycle 12.
    bus.start = 1'b1;
    bus.a     = 32'h1_0000;
    bus.b     = 32'h1_0000;
    next_cycle();
    bus.start = 1'b0;
    repeat (11) next_cycle();
    check("abort busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    check("abort hi", 64'(bus.hi), 64'd0);
    check("abort lo", 64'(bus.lo), 64'd0);
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    check("abort no_done", 64'(dones), 64'd0);
    next_cycle();

    run_op("4x4 after rst", 32'd4, 32'd4, L_4X4, 32'h0, 32'd16, 32'h0, 32'h0, -1, 1'b0);

    // Back-to-back: second start issued during the DONE cycle.
    run_op("6x7", 32'd6, 32'd7, L_6X7, 32'h0, 32'd42, 32'h0, 32'd16, -1, 1'b1);
    run_op("10x10 b2b", 32'd10, 32'd10, L_10X10, 32'h0, 32'd100, 32'h0, 32'd42, -1, 1'b0);

    run_op("9x0", 32'd9, 32'd0, L_9X0, 32'h0, 32'h0, 32'h0, 32'd100, -1, 1'b0);
    run_op("ffx1", 32'hFFFF_FFFF, 32'd1, L_FFX1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, -1, 1'b0);
    run_op("msbxmsb", 32'h8000_0000, 32'h8000_0000, L_MSB, 32'h4000_0000, 32'h0,
           32'h0, 32'hFFFF_FFFF, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_multu_seq

// File: doc/multu_seq.md
MULTU_SEQ -- requirements
Module: multu_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand width in bits; result width is 2*WIDTH.
REQ-002 SHALL provide port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port start  input  1  request to multiply; sampled only when the block can accept.
REQ-005 SHALL provide port a  input  WIDTH  unsigned multiplicand.
REQ-006 SHALL provide port b  input  WIDTH  unsigned multiplier.
REQ-007 SHALL provide port hi  output  WIDTH  upper half of the registered product.
REQ-008 SHALL provide port lo  output  WIDTH  lower half of the registered product.
REQ-009 SHALL provide port busy  output  1  high while an operation is in progress.
REQ-010 SHALL provide port done  output  1  one-cycle pulse when {hi,lo} becomes valid.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE or DONE; on accept it SHALL latch a and b, clear the accumulator and iteration counter, and enter RUN.
REQ-013 SHALL ignore start while in RUN; latched operands SHALL NOT change.
REQ-014 Each RUN cycle SHALL perform one radix-2 step: if the multiplier LSB is 1, add the 2*WIDTH-bit shifted multiplicand to the accumulator; shift the multiplicand left by 1; shift the multiplier right by 1; increment the counter.
REQ-015 Arithmetic SHALL be unsigned and modulo 2^(2*WIDTH); the accumulator cannot overflow.
REQ-016 With start high in cycle 0, busy SHALL be high in cycles 1..WIDTH, and done SHALL be high in cycle WIDTH+1 only (base latency).
REQ-017 {hi,lo} SHALL be written only on the RUN->DONE transition and SHALL hold their value otherwise, including during subsequent RUN cycles.
REQ-018 DONE SHALL last one cycle; it returns to IDLE, or to RUN if start is high in that cycle (back-to-back).
REQ-019 busy and done SHALL never be high in the same cycle.

Reset
REQ-020 While reset is low: state IDLE; hi, lo, busy, done, accumulator, counter and operand registers all 0.
REQ-021 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL operate normally.

Configuration
REQ-022 Macro MULTU_SEQ_EARLY_EXIT_EN SHALL enable early termination: RUN ends at the first step after which the remaining multiplier is zero. RUN lasts max(1, index of MSB of b + 1) cycles. b=0 gives one RUN cycle.
REQ-023 Without MULTU_SEQ_EARLY_EXIT_EN, RUN SHALL always last exactly WIDTH cycles, independent of the operands.
REQ-024 Results SHALL be identical with and without the macro; only the latency differs.

Structure
REQ-025 Shared package multu_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default width constant 32.
REQ-026 The single add-shift step SHALL be a combinational sub-module multu_step. It takes accumulator, multiplicand and multiplier and returns the next values. The FSM and counter SHALL remain in multu_seq.

Verification
REQ-027 a=3, b=5, start high in cycle 0 (macro off) -> busy high cycles 1..32; done in cycle 33; hi=0x00000000, lo=0x0000000F.
REQ-028 a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; hi/lo unchanged until the next done.
REQ-029 a=7, b=9 started; start pulsed again in cycle 10 with a=2, b=2 -> ignored; done in cycle 33 with lo=63.
REQ-030 Start a=0x10000, b=0x10000; pull reset low in cycle 12 -> all outputs 0 at once, no done pulse; after release, a=4, b=4 -> lo=16 in cycle 33 after that start.
REQ-031 Start a=6, b=7; start a=10, b=10 in the DONE cycle -> first done gives lo=42; second done 33 cycles later gives lo=100; no IDLE cycle between the two operations.
REQ-032 Macro on: a=3, b=5 -> done in cycle 4, lo=15; a=9, b=0 -> done in cycle 2, {hi,lo}=0; a=b=0xFFFFFFFF -> done in cycle 33.
